// File: rtl/trace_pkg.sv
// Shared types and constants for the datapath trace capture block.
// Entry layout, FSM encodings and default widths live here.
package trace_pkg;

    localparam int TRACE_TS_W = 16;
    localparam int ENTRY_W    = 96 + TRACE_TS_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STOPPED = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           instr;
        logic [31:0]           alu;
        logic [TRACE_TS_W-1:0] ts;
    } entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with registered storage, count and same-cycle push/pop.
// The head is read straight from storage, so a push is visible one edge later.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 112
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being written is the one leaving this cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pipeline_trace_capture.sv
// Records a timestamped entry each time the observed datapath PC changes.
// Arm/stop FSM, change detection and drop accounting around a trace FIFO.
module pipeline_trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = TRACE_TS_W,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            pc_in,
    input  logic [31:0]            instr_in,
    input  logic [31:0]            alu_in,
    input  logic                   arm,
    input  logic                   stop_en,
    input  logic [31:0]            stop_pc,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [31:0]            rd_pc,
    output logic [31:0]            rd_instr,
    output logic [31:0]            rd_alu,
    output logic [TS_W-1:0]        rd_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      dropped,
    output logic [1:0]             state_o
);

    localparam int EW = 96 + TS_W;

    state_e            state_q;
    state_e            state_d;
    logic [TS_W-1:0]   cyc_q;
    logic [31:0]       last_pc_q;
    logic              last_pc_valid_q;
    logic              overflow_q;
    logic [DROP_W-1:0] dropped_q;

    logic              evt;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;
    logic [EW-1:0]     wr_data;
    logic [EW-1:0]     rd_data;

    assign evt = (state_q == CAPTURE) &&
                 (!last_pc_valid_q || (pc_in != last_pc_q));
    assign pop      = rd_valid && rd_ready;
    assign drop     = evt && full && !pop;
    assign rd_valid = !empty;
    assign wr_data  = {pc_in, instr_in, alu_in, cyc_q};

    assign {rd_pc, rd_instr, rd_alu, rd_ts} = rd_data;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;
    assign state_o  = state_q;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (evt),
        .pop_i   (pop),
        .data_i  (wr_data),
        .data_o  (rd_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm) state_d = CAPTURE;
            CAPTURE: begin
                if (!arm)
                    state_d = IDLE;
                else if (evt && stop_en && (pc_in == stop_pc))
                    state_d = STOPPED;
            end
            STOPPED: if (!arm) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cyc_q           <= '0;
            last_pc_q       <= '0;
            last_pc_valid_q <= 1'b0;
            overflow_q      <= 1'b0;
            dropped_q       <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_q + TS_W'(1);
            // Re-arming forgets the old PC so a parked PC is captured again.
            if (state_q == IDLE && arm) begin
                last_pc_valid_q <= 1'b0;
            end else if (evt) begin
                last_pc_valid_q <= 1'b1;
                last_pc_q       <= pc_in;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (dropped_q != '1) dropped_q <= dropped_q + DROP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_trace_capture.sv
// Directed bench for pipeline_trace_capture with a queue-based reference.
// Every negedge compares the DUT against the model; literals pin key points.
module tb_pipeline_trace_capture;
    import trace_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [31:0] alu_in;
    logic        arm;
    logic        stop_en;
    logic [31:0] stop_pc;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [31:0] rd_alu;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  dropped;
    logic [1:0]  state_o;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_trace_capture #(
        .DEPTH  (16),
        .TS_W   (16),
        .DROP_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_in    (pc_in),
        .instr_in (instr_in),
        .alu_in   (alu_in),
        .arm      (arm),
        .stop_en  (stop_en),
        .stop_pc  (stop_pc),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_pc    (rd_pc),
        .rd_instr (rd_instr),
        .rd_alu   (rd_alu),
        .rd_ts    (rd_ts),
        .count    (count),
        .overflow (overflow),
        .dropped  (dropped),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: state number, queue of entries, simple counters.
    entry_t      m_q[$];
    entry_t      m_e;
    int          m_st   = 0;
    logic [15:0] m_cyc  = '0;
    logic [31:0] m_lpc  = '0;
    bit          m_lv   = 0;
    bit          m_ovf  = 0;
    int          m_drop = 0;
    bit          m_pop;
    bit          m_evt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_st   = 0;
            m_cyc  = '0;
            m_lv   = 0;
            m_lpc  = '0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            m_pop = rd_ready && (m_q.size() != 0);
            m_evt = (m_st == 1) && (!m_lv || pc_in != m_lpc);
            if (m_pop) void'(m_q.pop_front());
            if (m_evt) begin
                m_e.pc    = pc_in;
                m_e.instr = instr_in;
                m_e.alu   = alu_in;
                m_e.ts    = m_cyc;
                if (m_q.size() < 16) begin
                    m_q.push_back(m_e);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                m_lpc = pc_in;
                m_lv  = 1;
            end
            case (m_st)
                0: if (arm) begin m_st = 1; m_lv = 0; end
                1: begin
                    if (!arm) m_st = 0;
                    else if (m_evt && stop_en && pc_in == stop_pc) m_st = 2;
                end
                2: if (!arm) m_st = 0;
                default: m_st = 0;
            endcase
            m_cyc = m_cyc + 16'd1;
        end
    end

    always @(negedge clk) begin
        check("m_rd_valid", rd_valid, (m_q.size() != 0));
        check("m_count", count, m_q.size());
        check("m_state", state_o, m_st);
        check("m_overflow", overflow, m_ovf);
        check("m_dropped", dropped, m_drop);
        if (m_q.size() != 0) begin
            check("m_rd_pc", rd_pc, m_q[0].pc);
            check("m_rd_instr", rd_instr, m_q[0].instr);
            check("m_rd_alu", rd_alu, m_q[0].alu);
            check("m_rd_ts", rd_ts, m_q[0].ts);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expect(input string name, input logic [31:0] pc);
        check({name, "_valid"}, rd_valid, 1'b1);
        check({name, "_pc"}, rd_pc, pc);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    logic [31:0] t1_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] t1_in [3] = '{32'h20080005, 32'h20090003, 32'h01095020};
    logic [15:0] t1_ts [3] = '{16'd1, 16'd2, 16'd4};
    logic [31:0] t2_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

    initial begin
        reset    = 1'b0;
        pc_in    = '0;
        instr_in = '0;
        alu_in   = '0;
        arm      = 1'b0;
        stop_en  = 1'b0;
        stop_pc  = '0;
        rd_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", rd_valid, 1'b0);
        check("rst_count", count, 5'd0);
        check("rst_state", state_o, 2'd0);
        check("rst_pc", rd_pc, 32'h0);
        check("rst_ts", rd_ts, 16'h0);
        reset = 1'b1;

        // Basic change-detected capture
        arm = 1'b1;
        tick();
        check("t1_armed", state_o, 2'd1);
        pc_in = 32'h0; instr_in = 32'h20080005; alu_in = 32'd5;
        check("t1_valid_before", rd_valid, 1'b0);
        tick();
        check("t1_valid_after", rd_valid, 1'b1);
        pc_in = 32'h4; instr_in = 32'h20090003; alu_in = 32'd3;
        tick();
        tick();
        pc_in = 32'h8; instr_in = 32'h01095020; alu_in = 32'd8;
        tick();
        check("t1_count", count, 5'd3);
        for (int i = 0; i < 3; i++) begin
            check("t1_instr", rd_instr, t1_in[i]);
            check("t1_ts", rd_ts, t1_ts[i]);
            pop_expect("t1", t1_pc[i]);
        end
        arm = 1'b0;
        tick();
        check("t1_idle", state_o, 2'd0);

        // Stop on PC
        stop_en = 1'b1;
        stop_pc = 32'hC;
        arm     = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            pc_in = t2_pc[i];
            tick();
        end
        check("t2_stopped", state_o, 2'd2);
        pc_in = 32'h10;
        tick();
        check("t2_still_stopped", state_o, 2'd2);
        check("t2_count", count, 5'd4);
        for (int i = 0; i < 4; i++) pop_expect("t2", t2_pc[i]);
        arm     = 1'b0;
        stop_en = 1'b0;
        tick();
        check("t2_idle", state_o, 2'd0);

        // Overflow with consumer stalled
        arm = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            pc_in = 32'h100 + 32'(4 * i);
            tick();
        end
        check("t3_count", count, 5'd16);
        check("t3_overflow", overflow, 1'b1);
        check("t3_dropped", dropped, 8'd4);
        check("t3_head", rd_pc, 32'h100);

        // Full FIFO, push and pop together
        pc_in    = 32'h200;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t4_count", count, 5'd16);
        check("t4_dropped", dropped, 8'd4);
        for (int i = 1; i < 16; i++) pop_expect("t4", 32'h100 + 32'(4 * i));
        pop_expect("t4_last", 32'h200);
        check("t4_empty", count, 5'd0);

        // Re-arm recaptures a parked PC
        arm = 1'b0;
        tick();
        pc_in = 32'h40;
        arm   = 1'b1;
        tick();
        tick();
        check("t5_first", count, 5'd1);
        arm = 1'b0;
        tick();
        check("t5_idle", state_o, 2'd0);
        arm = 1'b1;
        tick();
        tick();
        check("t5_rearm", count, 5'd2);
        for (int i = 1; i < 4; i++) begin
            pc_in = 32'h40 + 32'(4 * i);
            tick();
        end
        check("t5_count5", count, 5'd5);
        check("t5_ovf_sticky", overflow, 1'b1);

        // Asynchronous reset mid-capture
        #1;
        reset = 1'b0;
        #1;
        check("t6_valid", rd_valid, 1'b0);
        check("t6_count", count, 5'd0);
        check("t6_state", state_o, 2'd0);
        check("t6_overflow", overflow, 1'b0);
        check("t6_dropped", dropped, 8'd0);
        tick();
        reset = 1'b1;
        arm   = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
